// File: rtl/oci_dct_pkg.sv
// Shared definitions for the OCI debug compressed trace unpacker.
// Symbol geometry defaults and the unpacker state encoding.
package oci_dct_pkg;

  localparam int SYM_W   = 2;
  localparam int NUM_SYM = 15;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    ENDED
  } state_t;

  typedef logic [SYM_W-1:0] sym_t;

endpackage

// File: rtl/oci_dct_unpacker.sv
// OCI DCT unpacker: splits packed trace frames into one symbol per cycle,
// LSB-first, and flags end of test once all accepted trace is drained.
module oci_dct_unpacker
  import oci_dct_pkg::*;
#(
  parameter int SYM_W_P   = SYM_W,
  parameter int NUM_SYM_P = NUM_SYM,
  parameter int CNT_W_P   = CNT_W,
  parameter int FRM_CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [SYM_W_P*NUM_SYM_P-1:0] dct_buffer,
  input  logic [CNT_W_P-1:0]           dct_count,
  input  logic                         test_ending,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [SYM_W_P-1:0]           out_sym,
  output logic                         out_last,
  output logic                         test_has_ended,
  output logic [FRM_CNT_W-1:0]         frames_done,
  output logic                         count_err
);

  localparam int BUF_W = SYM_W_P * NUM_SYM_P;
  localparam logic [CNT_W_P-1:0] MAX_CNT = CNT_W_P'(NUM_SYM_P);
  localparam logic [CNT_W_P-1:0] ONE     = CNT_W_P'(1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [BUF_W-1:0]     r_shift;
  logic [BUF_W-1:0]     w_shift_nxt;
  logic [CNT_W_P-1:0]   r_rem;
  logic [CNT_W_P-1:0]   w_rem_nxt;
  logic [FRM_CNT_W-1:0] r_frames;
  logic                 r_cnt_err;

  logic               w_last;
  logic               w_accept;
  logic               w_consume;
  logic               w_load;
  logic               w_over;
  logic [CNT_W_P-1:0] w_cnt_sat;

  assign w_last    = (r_rem == ONE);
  // Ready on the last symbol's consume gives zero-bubble frame chaining.
  assign in_ready  = (r_state == IDLE) ||
                     ((r_state == SHIFT) && w_last && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == SHIFT);
  assign w_consume = out_valid && out_ready;
  assign w_over    = (dct_count > MAX_CNT);
  assign w_cnt_sat = w_over ? MAX_CNT : dct_count;
  assign w_load    = w_accept && (dct_count != '0);

  assign out_sym        = out_valid ? r_shift[SYM_W_P-1:0] : '0;
  assign out_last       = out_valid && w_last;
  assign test_has_ended = (r_state == ENDED);
  assign frames_done    = r_frames;
  assign count_err      = r_cnt_err;

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_rem_nxt   = r_rem;
    if (w_consume) begin
      w_shift_nxt = r_shift >> SYM_W_P;
      w_rem_nxt   = r_rem - ONE;
    end
    unique case (r_state)
      IDLE: begin
        if (w_load)
          w_state_nxt = SHIFT;
        else if (!w_accept && test_ending)
          w_state_nxt = ENDED;
      end
      SHIFT: begin
        if (w_consume && w_last && !w_load)
          w_state_nxt = IDLE;
      end
      ENDED: w_state_nxt = ENDED;
      default: w_state_nxt = IDLE;
    endcase
    if (w_load) begin
      w_shift_nxt = dct_buffer;
      w_rem_nxt   = w_cnt_sat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_rem     <= '0;
      r_frames  <= '0;
      r_cnt_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_rem     <= w_rem_nxt;
      r_frames  <= r_frames + FRM_CNT_W'(w_accept);
      r_cnt_err <= r_cnt_err | (w_accept && w_over);
    end
  end

endmodule

// File: tb/tb_oci_dct_unpacker.sv
// Randomized and directed bench for oci_dct_unpacker against a
// queue-based model of the pending symbol stream.
module tb_oci_dct_unpacker;
  import oci_dct_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_ending;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_sym;
  logic        out_last;
  logic        test_has_ended;
  logic [15:0] frames_done;
  logic        count_err;

  always #5 clk = ~clk;

  oci_dct_unpacker dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_ending    (test_ending),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_sym        (out_sym),
    .out_last       (out_last),
    .test_has_ended (test_has_ended),
    .frames_done    (frames_done),
    .count_err      (count_err)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    sym_t sym;
    logic last;
  } item_t;

  item_t       q[$];
  logic        m_ended;
  int unsigned m_frames;
  logic        m_err;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_ended  = 1'b0;
    m_frames = 0;
    m_err    = 1'b0;
  endtask

  // One clock: check registered outputs, drive, check ready, advance model.
  task automatic step(input logic rst, input logic iv,
                      input logic [29:0] b, input logic [3:0] c,
                      input logic te, input logic ordy);
    logic m_rdy;
    logic acc;
    logic was_idle;
    int   n;
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("out_sym", 32'(out_sym), 32'(q[0].sym));
      chk("out_last", 32'(out_last), 32'(q[0].last));
    end else begin
      chk("out_sym_idle", 32'(out_sym), 0);
      chk("out_last_idle", 32'(out_last), 0);
    end
    chk("test_has_ended", 32'(test_has_ended), 32'(m_ended));
    chk("frames_done", 32'(frames_done), 32'(m_frames[15:0]));
    chk("count_err", 32'(count_err), 32'(m_err));
    reset       = rst;
    in_valid    = iv;
    dct_buffer  = b;
    dct_count   = c;
    test_ending = te;
    out_ready   = ordy;
    #1;
    m_rdy = !m_ended && (q.size() == 0 || (q.size() == 1 && ordy));
    if (!rst) chk("in_ready", 32'(in_ready), 32'(m_rdy));
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      acc      = iv && m_rdy;
      was_idle = (q.size() == 0);
      if (q.size() > 0 && ordy) void'(q.pop_front());
      if (acc) begin
        m_frames++;
        if (c > 15) m_err = 1'b1;
        n = (c > 15) ? 15 : int'(c);
        for (int i = 0; i < n; i++)
          q.push_back('{sym: b[2*i +: 2], last: (i == n - 1)});
      end else if (was_idle && te && !m_ended) begin
        m_ended = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, ordy);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; dct_buffer = '0;
    dct_count = '0; test_ending = 1'b0; out_ready = 1'b0;
    model_clear();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_frames", 32'(frames_done), 0);
    chk("rst_ended", 32'(test_has_ended), 0);

    // Two-symbol frame: 2'b11 then 2'b10 with last.
    step(0, 1, 30'h0000_001B, 4'd2, 0, 1);
    chk("f1_sym0", 32'(out_sym), 32'h3);
    idle(3, 1);
    chk("f1_frames", 32'(frames_done), 1);

    // Full frame with a second frame waiting behind it.
    step(0, 1, 30'h3FFF_FFFF, 4'd15, 0, 1);
    for (int i = 0; i < 15; i++) step(0, 1, 30'h0000_0039, 4'd3, 0, 1);
    idle(5, 1);

    // Empty frame then a single-symbol frame.
    step(1, 0, '0, '0, 0, 0);
    step(0, 1, 30'h3FFF_FFFF, 4'd0, 0, 1);
    step(0, 1, 30'h0000_0001, 4'd1, 0, 1);
    chk("single_sym", 32'(out_sym), 1);
    idle(2, 1);
    chk("single_frames", 32'(frames_done), 2);

    // Stalls during a four-symbol frame.
    step(0, 1, 30'h0000_00E4, 4'd4, 0, 1);
    for (int i = 0; i < 10; i++) step(0, 0, '0, '0, 0, 1'(i % 2));

    // End of test after a three-symbol frame.
    step(0, 1, 30'h0000_002D, 4'd3, 1, 1);
    idle(3, 1);
    step(0, 0, '0, '0, 1, 1);
    chk("ended_set", 32'(test_has_ended), 1);
    step(0, 1, 30'h1, 4'd1, 0, 1);
    chk("ended_ready", 32'(in_ready), 0);

    // Reset with five symbols left.
    step(1, 0, '0, '0, 0, 0);
    step(0, 1, 30'h2AAA_AAAA, 4'd15, 0, 1);
    idle(10, 1);
    step(1, 0, '0, '0, 0, 1);
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_frames", 32'(frames_done), 0);
    chk("mid_rst_ready", 32'(in_ready), 1);
    idle(4, 1);

    // Random traffic with occasional end-of-test and reset.
    for (int i = 0; i < 3000; i++)
      step(($urandom % 150) == 0, ($urandom % 3) != 0, 30'($urandom),
           4'($urandom_range(0, 15)), ($urandom % 60) == 0,
           ($urandom % 4) != 0);

    // Frame counter wrap via empty frames.
    step(1, 0, '0, '0, 0, 0);
    for (int i = 0; i < 65537; i++) step(0, 1, '0, 4'd0, 0, 1);
    chk("frames_wrap", 32'(frames_done), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/oci_dct_unpacker.md
Name: oci_dct_unpacker

Overview:
- Reader end of the OCI debug compressed trace (DCT) path.
- Accepts packed trace frames: a 30-bit dct_buffer holding up to 15 2-bit trace symbols, with dct_count giving the number of valid symbols.
- Emits the symbols one per cycle, LSB-first, over a valid/ready stream, and reports end of test once all accepted trace is drained.
- Sits between the OCI trace packer and the simulation/debug trace sink; pure RTL, synthesizable.

Parameters:
- SYM_W, 2, width of one trace symbol in bits.
- NUM_SYM, 15, maximum symbols per frame; buffer width is SYM_W*NUM_SYM = 30.
- CNT_W, 4, width of dct_count; must satisfy 2**CNT_W > NUM_SYM.
- FRM_CNT_W, 16, width of the accepted-frame counter.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  frame present on dct_buffer/dct_count.
- in_ready  out  1  unpacker accepts the frame this cycle.
- dct_buffer  in  30  packed symbols; symbol i = bits [2i+1:2i].
- dct_count  in  4  valid symbols in frame, 0..15; values above NUM_SYM are illegal.
- test_ending  in  1  level; producer will send no further frames.
- out_valid  out  1  out_sym valid.
- out_ready  in  1  sink accepts out_sym.
- out_sym  out  2  current trace symbol.
- out_last  out  1  out_sym is the final symbol of its frame.
- test_has_ended  out  1  sticky; all trace drained after test_ending.
- frames_done  out  16  count of accepted frames; wraps modulo 2**16.
- count_err  out  1  sticky; a frame with dct_count > NUM_SYM was accepted.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE.
  - in_ready = 1 on the first cycle after reset.
  - out_valid = 0, out_sym = 0, out_last = 0.
  - test_has_ended = 0, frames_done = 0, count_err = 0.
  - Reset mid-frame discards remaining symbols; no partial output after reset.
- States: IDLE (no frame held), SHIFT (frame held, remaining > 0), ENDED (terminal until reset).
- Handshakes:
  - A frame is accepted when in_valid && in_ready.
  - A symbol is consumed when out_valid && out_ready.
  - out_sym, out_last and out_valid hold stable while out_valid && !out_ready.
- in_ready = (state==IDLE) || (state==SHIFT && remaining==1 && out_ready). This allows back-to-back frames with zero bubble.
- Accept with count>0:
  - Load shift register = dct_buffer and remaining = count (saturated to NUM_SYM).
  - Go to SHIFT; out_valid rises the next cycle.
  - Latency: one cycle from accept to first symbol.
- Accept with count==0:
  - Frame is consumed; frames_done increments; no symbol is emitted; state stays IDLE.
- Consume in SHIFT:
  - Shift right by SYM_W and decrement remaining.
  - out_last = (remaining==1).
  - When remaining reaches 0 with no simultaneous accept, go to IDLE.
- Consume of the last symbol with a simultaneous accept: load the new frame in the same cycle; out_valid stays 1.
- count > NUM_SYM:
  - Frame is accepted; only NUM_SYM symbols are emitted; count_err is set.
- frames_done increments on every accept and wraps from 0xFFFF to 0.
- End of test:
  - In IDLE with test_ending=1 and no accept this cycle, go to ENDED.
  - In ENDED: test_has_ended = 1, in_ready = 0, out_valid = 0.
  - A frame offered in the same cycle as test_ending while IDLE is accepted and drained first.
- test_ending deasserting after ENDED has no effect.

Decomposition:
- Package oci_dct_pkg holds:
  - the SYM_W, NUM_SYM and CNT_W defaults;
  - the state enum {IDLE, SHIFT, ENDED};
  - the symbol type, defined as a SYM_W-bit vector.
- No sub-module; the shift register, counter and FSM stay in one module.

Test Plan:
- Reset, then one frame dct_buffer=30'h0000_001B, count=2 -> out_sym 2'b11 then 2'b10; out_last on the 2nd symbol; frames_done=1.
- Full frame 30'h3FFF_FFFF, count=15, out_ready always 1 -> 15 symbols of 2'b11 on consecutive cycles; a second frame offered meanwhile is accepted on the 15th symbol with no bubble.
- count=0 frame, then count=1 frame with buffer=1 -> single symbol 2'b01; frames_done=2.
- out_ready toggled 1/0 during a count=4 frame, buffer=30'h0E4 -> symbols 0,1,2,3 in order; outputs stable while stalled.
- Frame with count=3, then test_ending=1 -> test_has_ended rises exactly one cycle after the 3rd symbol is consumed; in_ready=0 thereafter.
- Assert reset during SHIFT with 5 symbols remaining -> next cycle out_valid=0, frames_done=0, in_ready=1, no stray symbols.
